// File: rtl/bwe_pkg.sv
// rtl/bwe_pkg.sv - shared state encoding and default train parameters for the probe-train judge.
package bwe_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        REPORT     = 2'd3
    } state_e;

    localparam int PKT_NUMBER   = 4;
    localparam int SENDER_IPD   = 10;
    localparam int TOTAL_CYCLES = 162;

endpackage

// File: rtl/ipd_meter.sv
// rtl/ipd_meter.sv - saturating inter-packet-delay timer; exposes the running delay as a sample on arrival.
module ipd_meter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         first_i,
    input  logic         enable_i,
    input  logic         arrival_i,
    output logic [W-1:0] sample_o,
    output logic         sample_valid_o
);

    logic [W-1:0] timer_q;
    logic [W-1:0] timer_d;

    // Reloading 1 on an arrival makes the timer equal the edge-to-edge distance at the next arrival.
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (first_i) begin
            timer_d = W'(1);
        end else if (enable_i) begin
            if (arrival_i) begin
                timer_d = W'(1);
            end else if (timer_q != '1) begin
                timer_d = timer_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign sample_o       = timer_q;
    assign sample_valid_o = enable_i & arrival_i;

endmodule

// File: rtl/bwe_train_judge.sv
// rtl/bwe_train_judge.sv - measures one probe train's receive IPDs and issues a congested/timeout verdict.
module bwe_train_judge #(
    parameter int PKT_NUMBER      = bwe_pkg::PKT_NUMBER,
    parameter int SENDER_IPD      = bwe_pkg::SENDER_IPD,
    parameter int TOTAL_CYCLES    = bwe_pkg::TOTAL_CYCLES,
    parameter int DISPERSE_THRESH = 3,
    parameter int W               = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pktArrival,
    output logic         busy,
    output logic         result_valid,
    output logic [W-1:0] disp_cnt,
    output logic [W-1:0] ipd_sum,
    output logic [W-1:0] ipd_max,
    output logic [W-1:0] pkt_seen,
    output logic         congested,
    output logic         timeout
);
    import bwe_pkg::*;

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] win_timer_q, win_timer_d;
    logic [W-1:0] disp_cnt_q,  disp_cnt_d;
    logic [W-1:0] ipd_sum_q,   ipd_sum_d;
    logic [W-1:0] ipd_max_q,   ipd_max_d;
    logic [W-1:0] pkt_seen_q,  pkt_seen_d;
    logic         congested_q, congested_d;
    logic         timeout_q,   timeout_d;

    logic         accept;
    logic         in_window;
    logic         first_arr;
    logic [W-1:0] win_inc;
    logic         window_done;
    logic         train_done;
    logic         report_now;
    logic [W-1:0] sample;
    logic         sample_valid;
    logic [W:0]   sum_ext;

    assign accept      = (state_q == IDLE) && start;
    assign in_window   = (state_q == WAIT_FIRST) || (state_q == MEASURE);
    assign first_arr   = (state_q == WAIT_FIRST) && pktArrival;
    assign win_inc     = (win_timer_q == '1) ? win_timer_q : win_timer_q + W'(1);
    assign window_done = in_window && (win_inc >= W'(TOTAL_CYCLES));
    assign train_done  = sample_valid && ((pkt_seen_q + W'(1)) == W'(PKT_NUMBER));
    // A final arrival on the expiry edge still completes the train, so it wins over the timeout.
    assign report_now  = in_window && (train_done || window_done);

    ipd_meter #(.W(W)) u_ipd_meter (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (accept),
        .first_i        (first_arr),
        .enable_i       (state_q == MEASURE),
        .arrival_i      (pktArrival),
        .sample_o       (sample),
        .sample_valid_o (sample_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (accept)          state_d = WAIT_FIRST;
            WAIT_FIRST: if (window_done)     state_d = REPORT;
                        else if (first_arr)  state_d = MEASURE;
            MEASURE:    if (report_now)      state_d = REPORT;
            REPORT:                          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != IDLE);
        result_valid = (state_q == REPORT);
    end

    always_comb begin
        win_timer_d = win_timer_q;
        disp_cnt_d  = disp_cnt_q;
        ipd_sum_d   = ipd_sum_q;
        ipd_max_d   = ipd_max_q;
        pkt_seen_d  = pkt_seen_q;
        congested_d = congested_q;
        timeout_d   = timeout_q;
        sum_ext     = {1'b0, ipd_sum_q} + {1'b0, sample};
        if (accept) begin
            win_timer_d = '0;
            disp_cnt_d  = '0;
            ipd_sum_d   = '0;
            ipd_max_d   = '0;
            pkt_seen_d  = '0;
            congested_d = 1'b0;
            timeout_d   = 1'b0;
        end else if (in_window) begin
            win_timer_d = win_inc;
            if (first_arr) begin
                pkt_seen_d = W'(1);
            end else if (sample_valid) begin
                disp_cnt_d = disp_cnt_q + W'(sample >= W'(SENDER_IPD));
                ipd_sum_d  = sum_ext[W] ? '1 : sum_ext[W-1:0];
                ipd_max_d  = (sample > ipd_max_q) ? sample : ipd_max_q;
                pkt_seen_d = pkt_seen_q + W'(1);
            end
            if (report_now) begin
                timeout_d   = !train_done;
                congested_d = (disp_cnt_d >= W'(DISPERSE_THRESH));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_timer_q <= '0;
            disp_cnt_q  <= '0;
            ipd_sum_q   <= '0;
            ipd_max_q   <= '0;
            pkt_seen_q  <= '0;
            congested_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            win_timer_q <= win_timer_d;
            disp_cnt_q  <= disp_cnt_d;
            ipd_sum_q   <= ipd_sum_d;
            ipd_max_q   <= ipd_max_d;
            pkt_seen_q  <= pkt_seen_d;
            congested_q <= congested_d;
            timeout_q   <= timeout_d;
        end
    end

    assign disp_cnt  = disp_cnt_q;
    assign ipd_sum   = ipd_sum_q;
    assign ipd_max   = ipd_max_q;
    assign pkt_seen  = pkt_seen_q;
    assign congested = congested_q;
    assign timeout   = timeout_q;

endmodule
